// File: rtl/rs_dec_pkg.sv
// Shared constants and types for the RS(544,522) decoder back end.
package rs_dec_pkg;
    localparam int W     = 10;
    localparam int POS_W = 10;
    localparam int N     = 544;
    localparam int T     = 11;
    localparam int DEG_W = 4;
    localparam int CNT_W = 5;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [W-1:0]     y;
    } err_ent_t;

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} apply_st_e;
endpackage

// File: rtl/rs_err_fifo.sv
// Error-entry FIFO; pointers carry an extra wrap bit to tell full from empty.
module rs_err_fifo
    import rs_dec_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  err_ent_t                 din_i,
    output err_ent_t                 head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    err_ent_t    mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push_ok, pop_ok;

    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_o = (wr_ptr == rd_ptr);
    assign count_o = wr_ptr - rd_ptr;
    assign head_o  = mem[rd_ptr[AW-1:0]];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/forney_err_apply.sv
// Merges the ascending Forney error list into the received stream and flags decode failure.
// Optional FORNEY_ERR_APPLY_STATS_EN adds correction/failure statistics ports.
module forney_err_apply
    import rs_dec_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             deg_vld_i,
    output logic             deg_rdy_o,
    input  logic [DEG_W-1:0] deg_i,
    input  logic             s2_vld_i,
    output logic             s2_rdy_o,
    input  logic [POS_W-1:0] pos_i,
    input  logic [W-1:0]     y_i,
    input  logic             den_zero_i,
    input  logic             err_done_i,
    input  logic             sym_vld_i,
    output logic             sym_rdy_o,
    input  logic [W-1:0]     sym_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [W-1:0]     out_sym_o,
    output logic             out_last_o,
    output logic             out_fail_o
`ifdef FORNEY_ERR_APPLY_STATS_EN
    ,
    output logic [3:0]       corr_cnt_o,
    output logic [15:0]      fail_cnt_o
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    apply_st_e        state_q, state_d;
    logic [DEG_W-1:0] deg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fail_q, done_q, sym_end_q, prev_vld_q;
    logic [POS_W-1:0] prev_pos_q, sym_idx_q;
    logic             out_vld_q, out_last_q, out_fail_q;
    logic [W-1:0]     out_sym_q;

    err_ent_t         head, push_ent;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_cnt;

    logic deg_fire, s2_fire, sym_fire, out_fire, last_out_fire;
    logic ent_ok, push, pop, hit, is_last, can_dec, out_free, left_over, fail_last;

    assign deg_fire      = deg_vld_i && deg_rdy_o;
    assign s2_fire       = s2_vld_i && s2_rdy_o;
    assign sym_fire      = sym_vld_i && sym_rdy_o;
    assign out_fire      = out_vld_q && out_rdy_i;
    assign last_out_fire = out_fire && out_last_q;

    assign ent_ok = (pos_i < POS_W'(N)) && (!prev_vld_q || (pos_i > prev_pos_q))
                 && !den_zero_i && (cnt_q < CNT_W'(deg_q));
    assign push     = s2_fire && ent_ok;
    assign push_ent = '{pos: pos_i, y: y_i};

    assign is_last  = (sym_idx_q == POS_W'(N-1));
    assign hit      = !fifo_empty && (head.pos == sym_idx_q);
    // The last symbol waits for done so the final count check sees the whole list.
    assign can_dec  = !sym_end_q && (is_last ? done_q : (done_q || !fifo_empty));
    assign out_free = !out_vld_q || out_rdy_i;
    assign pop      = sym_fire && hit;

    assign left_over = (fifo_cnt != CW'(pop));
    assign fail_last = fail_q || (cnt_q != CNT_W'(deg_q)) || (deg_q > DEG_W'(T)) || left_over;

    rs_err_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (deg_fire),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_ent),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (deg_fire) state_d = COLLECT;
            COLLECT: if (last_out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        deg_rdy_o = 1'b0;
        s2_rdy_o  = 1'b0;
        sym_rdy_o = 1'b0;
        case (state_q)
            IDLE:    deg_rdy_o = 1'b1;
            COLLECT: begin
                s2_rdy_o  = !fifo_full && !done_q;
                sym_rdy_o = can_dec && out_free;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deg_q      <= '0;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            done_q     <= 1'b0;
            sym_end_q  <= 1'b0;
            sym_idx_q  <= '0;
            prev_pos_q <= '0;
            prev_vld_q <= 1'b0;
        end else if (deg_fire) begin
            deg_q      <= deg_i;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            done_q     <= err_done_i;
            sym_end_q  <= 1'b0;
            sym_idx_q  <= '0;
            prev_vld_q <= 1'b0;
        end else if (state_q == COLLECT) begin
            if (s2_fire) begin
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                if (ent_ok) begin
                    prev_pos_q <= pos_i;
                    prev_vld_q <= 1'b1;
                end else begin
                    fail_q <= 1'b1;
                end
            end
            if (err_done_i) done_q <= 1'b1;
            if (sym_fire) begin
                if (is_last) sym_end_q <= 1'b1;
                else         sym_idx_q <= sym_idx_q + POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            out_sym_q  <= '0;
            out_last_q <= 1'b0;
            out_fail_q <= 1'b0;
        end else if (sym_fire) begin
            out_vld_q  <= 1'b1;
            out_sym_q  <= hit ? (sym_i ^ head.y) : sym_i;
            out_last_q <= is_last;
            out_fail_q <= is_last && fail_last;
        end else if (out_rdy_i) begin
            out_vld_q  <= 1'b0;
        end
    end

    assign out_vld_o  = out_vld_q;
    assign out_sym_o  = out_sym_q;
    assign out_last_o = out_last_q;
    assign out_fail_o = out_fail_q;

`ifdef FORNEY_ERR_APPLY_STATS_EN
    logic [3:0] corr_run_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_run_q <= '0;
            corr_cnt_o <= '0;
            fail_cnt_o <= '0;
        end else begin
            if (deg_fire)                      corr_run_q <= '0;
            else if (pop && corr_run_q != '1)  corr_run_q <= corr_run_q + 4'd1;
            if (last_out_fire) begin
                corr_cnt_o <= corr_run_q;
                if (out_fail_q && fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_forney_err_apply.sv
// Directed table-driven bench for forney_err_apply plus mid-codeword reset sequence.
module tb_forney_err_apply;
    localparam int N  = 544;
    localparam int NV = 10;

    logic       clk_i, rst_ni;
    logic       deg_vld_i, deg_rdy_o;
    logic [3:0] deg_i;
    logic       s2_vld_i, s2_rdy_o, den_zero_i, err_done_i;
    logic [9:0] pos_i, y_i;
    logic       sym_vld_i, sym_rdy_o;
    logic [9:0] sym_i;
    logic       out_vld_o, out_rdy_i, out_last_o, out_fail_o;
    logic [9:0] out_sym_o;
`ifdef FORNEY_ERR_APPLY_STATS_EN
    logic [3:0]  corr_cnt_o;
    logic [15:0] fail_cnt_o;
`endif

    forney_err_apply dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .deg_vld_i(deg_vld_i), .deg_rdy_o(deg_rdy_o), .deg_i(deg_i),
        .s2_vld_i(s2_vld_i), .s2_rdy_o(s2_rdy_o), .pos_i(pos_i), .y_i(y_i),
        .den_zero_i(den_zero_i), .err_done_i(err_done_i),
        .sym_vld_i(sym_vld_i), .sym_rdy_o(sym_rdy_o), .sym_i(sym_i),
        .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .out_sym_o(out_sym_o),
        .out_last_o(out_last_o), .out_fail_o(out_fail_o)
`ifdef FORNEY_ERR_APPLY_STATS_EN
        , .corr_cnt_o(corr_cnt_o), .fail_cnt_o(fail_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        int deg; int n_err; int err_dly; int done_dly; int seed; int n_fix;
        bit rdy_tog; bit exp_fail;
        logic [11:0][9:0] epos; logic [11:0][9:0] ey; logic [11:0] edz;
        logic [11:0][9:0] fpos; logic [11:0][9:0] fy;
    } vec_t;

    vec_t       tv [NV];
    int         n_chk = 0, n_err = 0, n_got = 0;
    logic [9:0] got_sym [N];
    bit         got_last [N], got_fail [N];

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [9:0] sym_val(int k, int seed);
        int v;
        if (seed == 0) return 10'h155;
        v = (k * 37) ^ seed;
        return v[9:0];
    endfunction

    task automatic set_case(int c, int deg, int ne, int edly, int ddly, int seed, bit tog, bit f);
        tv[c] = '0;
        tv[c].deg = deg; tv[c].n_err = ne; tv[c].err_dly = edly; tv[c].done_dly = ddly;
        tv[c].seed = seed; tv[c].rdy_tog = tog; tv[c].exp_fail = f;
    endtask
    task automatic set_err(int c, int j, int p, int y, bit dz);
        tv[c].epos[j] = 10'(p); tv[c].ey[j] = 10'(y); tv[c].edz[j] = dz;
    endtask
    task automatic set_fix(int c, int p, int y);
        tv[c].fpos[tv[c].n_fix] = 10'(p); tv[c].fy[tv[c].n_fix] = 10'(y);
        tv[c].n_fix++;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_out_vld"}, out_vld_o, 0);
        chk({tag, "_out_sym"}, out_sym_o, 0);
        chk({tag, "_out_last"}, out_last_o, 0);
        chk({tag, "_out_fail"}, out_fail_o, 0);
        chk({tag, "_deg_rdy"}, deg_rdy_o, 1);
        chk({tag, "_s2_rdy"}, s2_rdy_o, 0);
        chk({tag, "_sym_rdy"}, sym_rdy_o, 0);
    endtask

    task automatic send_deg(int d);
        bit ok; int b = 0;
        deg_vld_i = 1'b1; deg_i = 4'(d);
        do begin
            @(negedge clk_i); ok = deg_rdy_o;
            @(posedge clk_i); #1; b++;
        end while (!ok && b < 100);
        deg_vld_i = 1'b0;
        if (!ok) chk("deg_handshake", 0, 1);
    endtask

    task automatic drive_errs(int c, int tag);
        bit ok; int b;
        repeat (tv[c].err_dly) @(posedge clk_i);
        #1;
        if (tv[c].err_dly > 0) chk($sformatf("c%0d_stall_before_errs", tag), n_got, 0);
        for (int j = 0; j < tv[c].n_err; j++) begin
            s2_vld_i = 1'b1; pos_i = tv[c].epos[j]; y_i = tv[c].ey[j]; den_zero_i = tv[c].edz[j];
            b = 0;
            do begin
                @(negedge clk_i); ok = s2_rdy_o;
                @(posedge clk_i); #1; b++;
            end while (!ok && b < 3000);
            if (!ok) chk($sformatf("c%0d_s2_handshake", tag), 0, 1);
        end
        s2_vld_i = 1'b0; den_zero_i = 1'b0;
        repeat (tv[c].done_dly) @(posedge clk_i);
        #1;
        if (tv[c].done_dly > 0) chk($sformatf("c%0d_last_stall", tag), n_got, N-1);
        err_done_i = 1'b1;
        @(posedge clk_i); #1;
        err_done_i = 1'b0;
    endtask

    task automatic drive_syms(int seed, int n, int tag);
        bit ok; int b; int sent = 0;
        for (int k = 0; k < n; k++) begin
            sym_vld_i = 1'b1; sym_i = sym_val(k, seed);
            b = 0;
            do begin
                @(negedge clk_i); ok = sym_rdy_o;
                @(posedge clk_i); #1; b++;
            end while (!ok && b < 3000);
            if (!ok) break;
            sent++;
        end
        sym_vld_i = 1'b0;
        chk($sformatf("c%0d_syms_sent", tag), sent, n);
    endtask

    task automatic collect(bit tog);
        int cyc = 0;
        while (n_got < N && cyc < 20000) begin
            out_rdy_i = tog ? cyc[0] : 1'b1;
            @(negedge clk_i);
            if (out_vld_o && out_rdy_i) begin
                got_sym[n_got] = out_sym_o; got_last[n_got] = out_last_o;
                got_fail[n_got] = out_fail_o; n_got++;
            end
            @(posedge clk_i); #1; cyc++;
        end
        out_rdy_i = 1'b0;
    endtask

    task automatic run_case(int c, int tag);
        int mism = 0, first = -1, nlast = 0;
        logic [9:0] e;
        n_got = 0;
        send_deg(tv[c].deg);
        fork
            drive_errs(c, tag);
            drive_syms(tv[c].seed, N, tag);
            collect(tv[c].rdy_tog);
        join
        chk($sformatf("c%0d_out_count", tag), n_got, N);
        for (int k = 0; k < n_got; k++) begin
            e = sym_val(k, tv[c].seed);
            for (int j = 0; j < tv[c].n_fix; j++)
                if (int'(tv[c].fpos[j]) == k) e = e ^ tv[c].fy[j];
            if (got_sym[k] !== e) begin
                if (first < 0) begin
                    first = k;
                    $display("  c%0d first bad idx %0d: got %03h want %03h", tag, k, got_sym[k], e);
                end
                mism++;
            end
            if (got_last[k]) nlast++;
        end
        chk($sformatf("c%0d_data_mismatches", tag), mism, 0);
        chk($sformatf("c%0d_last_flag", tag), int'(nlast == 1 && n_got == N && got_last[N-1]), 1);
        if (n_got == N) chk($sformatf("c%0d_fail_flag", tag), got_fail[N-1], tv[c].exp_fail);
        chk($sformatf("c%0d_idle_after", tag), deg_rdy_o, 1);
    endtask

    initial begin
        rst_ni = 1'b0; deg_vld_i = 0; deg_i = 0; s2_vld_i = 0; pos_i = 0; y_i = 0;
        den_zero_i = 0; err_done_i = 0; sym_vld_i = 0; sym_i = 0; out_rdy_i = 0;

        set_case(0, 0, 0, 0, 0, 0, 0, 0);
        set_case(1, 2, 2, 0, 0, 'h2A5, 0, 0);
        set_err(1, 0, 5, 'h3FF, 0); set_err(1, 1, 543, 'h001, 0);
        set_fix(1, 5, 'h3FF); set_fix(1, 543, 'h001);
        set_case(2, 3, 2, 0, 0, 'h0F3, 0, 1);
        set_err(2, 0, 100, 'h011, 0); set_err(2, 1, 200, 'h022, 0);
        set_fix(2, 100, 'h011); set_fix(2, 200, 'h022);
        set_case(3, 2, 2, 0, 0, 'h13C, 0, 1);
        set_err(3, 0, 10, 'h0AB, 1); set_err(3, 1, 30, 'h0CD, 0);
        set_fix(3, 30, 'h0CD);
        set_case(4, 2, 2, 0, 0, 'h3A1, 0, 1);
        set_err(4, 0, 20, 'h111, 0); set_err(4, 1, 7, 'h222, 0);
        set_fix(4, 20, 'h111);
        set_case(5, 3, 3, 50, 0, 'h05A, 1, 0);
        set_err(5, 0, 3, 'h001, 0); set_err(5, 1, 300, 'h2AA, 0); set_err(5, 2, 540, 'h3FF, 0);
        set_fix(5, 3, 'h001); set_fix(5, 300, 'h2AA); set_fix(5, 540, 'h3FF);
        set_case(6, 12, 12, 0, 0, 'h1E7, 0, 1);
        for (int j = 0; j < 12; j++) begin
            set_err(6, j, 10 + 40*j, (j*85 + 1) & 'h3FF, 0);
            set_fix(6, 10 + 40*j, (j*85 + 1) & 'h3FF);
        end
        set_case(7, 2, 2, 0, 0, 0, 0, 1);
        set_err(7, 0, 0, 'h155, 0); set_err(7, 1, 544, 'h001, 0);
        set_fix(7, 0, 'h155);
        set_case(8, 1, 2, 0, 0, 'h2C8, 0, 1);
        set_err(8, 0, 1, 'h001, 0); set_err(8, 1, 2, 'h002, 0);
        set_fix(8, 1, 'h001);
        set_case(9, 1, 1, 0, 700, 'h311, 0, 0);
        set_err(9, 0, 543, 'h0F0, 0);
        set_fix(9, 543, 'h0F0);

        repeat (2) @(posedge clk_i);
        #1;
        chk_reset("por");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int c = 0; c < NV; c++) run_case(c, c);

        // Reset in the middle of a codeword, then decode a fresh one.
        out_rdy_i = 1'b1;
        send_deg(0);
        err_done_i = 1'b1;
        @(posedge clk_i); #1;
        err_done_i = 1'b0;
        drive_syms(0, 300, 99);
        rst_ni = 1'b0;
        #1;
        chk_reset("mid");
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1; out_rdy_i = 1'b0;
        @(posedge clk_i); #1;
        run_case(1, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
